// File: rtl/clk_div_bank_pkg.sv
// Shared definitions for the programmable clock-divider bank: common
// divisor presets for a 50 MHz board clock and width helper functions.
package clk_div_bank_pkg;

  // Half-period divisors at 50 MHz (tick period D, square wave period 2*D).
  localparam int unsigned DIV_1HZ   = 32'd25000000;
  localparam int unsigned DIV_1KHZ  = 32'd25000;
  localparam int unsigned DIV_10KHZ = 32'd2500;

  // Ceiling log2 used to size the channel-select field.
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    return result;
  endfunction

  // Channel-select width; a single channel still gets a one-bit field.
  function automatic int chan_sel_width(input int nch);
    int bits;
    bits = clog2(nch);
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/pending divisor registers and the
// registered tick and square-wave outputs. Divisor changes are held
// pending and only take effect at a period boundary so no period is cut short.
module clk_div_chan
  import clk_div_bank_pkg::*;
#(
  parameter int          W       = 26,
  parameter int unsigned DEF_DIV = DIV_1HZ
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_enable,
  input  logic         i_sync,
  input  logic         i_wr_en,
  input  logic [W-1:0] i_wr_div,
  output logic         o_tick,
  output logic         o_clk_out,
  output logic         o_pend
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] r_act_div;
  logic [W-1:0] r_pend_div;
  logic         r_pend;
  logic         r_tick;
  logic         r_clk_out;

  logic [W-1:0] w_last;
  logic [W-1:0] w_cnt_inc;
  logic [W-1:0] w_wr_val;
  logic         w_tc;
  logic         w_apply;

  // The ">=" also catches a counter left beyond a divisor that shrank while
  // the channel was disabled, so it wraps on the next enabled edge.
  assign w_last    = r_act_div - W'(1);
  assign w_cnt_inc = r_cnt + W'(1);
  assign w_tc      = i_enable && (r_cnt >= w_last);

  // A zero divisor would never reach terminal count, so it becomes 1.
  assign w_wr_val  = (i_wr_div == '0) ? W'(1) : i_wr_div;

  // A pending divisor is safe to adopt on sync, while idle, or at the end
  // of the current period; never in the middle of an enabled period.
  assign w_apply   = r_pend && (i_sync || !i_enable || w_tc);

  // Counter, tick pulse and square wave; sync restarts the phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_tick    <= 1'b0;
      r_clk_out <= 1'b0;
    end else if (i_sync) begin
      r_cnt     <= '0;
      r_tick    <= 1'b0;
      r_clk_out <= 1'b0;
    end else if (i_enable) begin
      if (w_tc) begin
        r_cnt     <= '0;
        r_tick    <= 1'b1;
        r_clk_out <= ~r_clk_out;
      end else begin
        r_cnt  <= w_cnt_inc;
        r_tick <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  // Divisor bookkeeping; a write on the same edge as an apply leaves the
  // new value pending while the older one goes active.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_act_div  <= W'(DEF_DIV);
      r_pend_div <= '0;
      r_pend     <= 1'b0;
    end else begin
      if (w_apply) begin
        r_act_div <= r_pend_div;
      end
      if (i_wr_en) begin
        r_pend_div <= w_wr_val;
        r_pend     <= 1'b1;
      end else if (w_apply) begin
        r_pend     <= 1'b0;
      end
    end
  end

  assign o_tick    = r_tick;
  assign o_clk_out = r_clk_out;
  assign o_pend    = r_pend;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH independent programmable clock dividers sharing one board
// clock, one divisor write port and a common phase-align input.
module clk_div_bank
  import clk_div_bank_pkg::*;
#(
  parameter int          NCH     = 4,
  parameter int          W       = 26,
  parameter int unsigned DEF_DIV = DIV_1HZ,
  parameter int          CW      = chan_sel_width(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] i_enable,
  input  logic           i_sync,
  input  logic           i_wr_en,
  input  logic [CW-1:0]  i_wr_ch,
  input  logic [W-1:0]   i_wr_div,
  output logic [NCH-1:0] o_tick,
  output logic [NCH-1:0] o_clk_out,
  output logic [NCH-1:0] o_pend
);

  logic           w_addr_ok;
  logic [NCH-1:0] w_wr_hit;

  // Addresses past the last channel are dropped rather than aliased.
  assign w_addr_ok = (int'(i_wr_ch) < NCH);

  // One-hot write decode so each channel sees only its own strobe.
  always_comb begin
    w_wr_hit = '0;
    if (i_wr_en && w_addr_ok) begin
      for (int k = 0; k < NCH; k++) begin
        if (i_wr_ch == CW'(k)) begin
          w_wr_hit[k] = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clk_div_chan #(
      .W       (W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .i_enable  (i_enable[g]),
      .i_sync    (i_sync),
      .i_wr_en   (w_wr_hit[g]),
      .i_wr_div  (i_wr_div),
      .o_tick    (o_tick[g]),
      .o_clk_out (o_clk_out[g]),
      .o_pend    (o_pend[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: a 4-channel bank (W=8, DEF_DIV=5) for the
// main behaviour plus a 5-channel bank to exercise an out-of-range write.
module tb_clk_div_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] enable;
  logic       sync;
  logic       wr_en;
  logic [1:0] wr_ch;
  logic [7:0] wr_div;
  logic [3:0] tick;
  logic [3:0] clk_out;
  logic [3:0] pend;

  logic [4:0] enable5;
  logic       wr_en5;
  logic [2:0] wr_ch5;
  logic [7:0] wr_div5;
  logic [4:0] tick5;
  logic [4:0] clk_out5;
  logic [4:0] pend5;

  int checks   = 0;
  int failures = 0;

  clk_div_bank #(.NCH(4), .W(8), .DEF_DIV(5)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .i_enable  (enable),
    .i_sync    (sync),
    .i_wr_en   (wr_en),
    .i_wr_ch   (wr_ch),
    .i_wr_div  (wr_div),
    .o_tick    (tick),
    .o_clk_out (clk_out),
    .o_pend    (pend)
  );

  clk_div_bank #(.NCH(5), .W(8), .DEF_DIV(3)) u_dut5 (
    .clk       (clk),
    .reset     (reset),
    .i_enable  (enable5),
    .i_sync    (1'b0),
    .i_wr_en   (wr_en5),
    .i_wr_ch   (wr_ch5),
    .i_wr_div  (wr_div5),
    .o_tick    (tick5),
    .o_clk_out (clk_out5),
    .o_pend    (pend5)
  );

  // Free-running board clock.
  always #5 clk = ~clk;

  // Safety net in case the run never reaches its summary.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one edge's worth of write/sync inputs, then settle past the edge.
  task automatic applyStimulus(input logic we, input logic [1:0] ch,
                               input logic [7:0] dv, input logic sy);
    wr_en  = we;
    wr_ch  = ch;
    wr_div = dv;
    sync   = sy;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    sync  = 1'b0;
  endtask

  task automatic doReset();
    reset   = 1'b1;
    enable  = 4'h0;
    sync    = 1'b0;
    wr_en   = 1'b0;
    wr_ch   = 2'd0;
    wr_div  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    enable = 4'hF;
  endtask

  logic [3:0] expT;
  logic [3:0] expC;
  logic [3:0] expP;

  initial begin
    enable5 = 5'h1F;
    wr_en5  = 1'b0;
    wr_ch5  = 3'd0;
    wr_div5 = 8'd0;

    // Reset state and default divisor 5 on every channel.
    doReset();
    checkOutput("reset_tick", 32'(tick), 32'h0);
    checkOutput("reset_clk_out", 32'(clk_out), 32'h0);
    checkOutput("reset_pend", 32'(pend), 32'h0);
    for (int e = 1; e <= 15; e++) begin
      applyStimulus(1'b0, 2'd0, 8'd0, 1'b0);
      expT = (e % 5 == 0) ? 4'hF : 4'h0;
      expC = ((e / 5) % 2 == 1) ? 4'hF : 4'h0;
      checkOutput($sformatf("def_tick_e%0d", e), 32'(tick), 32'(expT));
      checkOutput($sformatf("def_clk_e%0d", e), 32'(clk_out), 32'(expC));
      checkOutput($sformatf("def_pend_e%0d", e), 32'(pend), 32'h0);
    end

    // Write ch1 div=3 on edge 2; applied at its edge-5 terminal count.
    doReset();
    for (int e = 1; e <= 15; e++) begin
      applyStimulus(e == 2, 2'd1, 8'd3, 1'b0);
      expT = (e % 5 == 0) ? 4'b1101 : 4'b0000;
      expT[1] = (e == 5) || (e == 8) || (e == 11) || (e == 14);
      expP = (e >= 2 && e < 5) ? 4'b0010 : 4'b0000;
      checkOutput($sformatf("wr3_tick_e%0d", e), 32'(tick), 32'(expT));
      checkOutput($sformatf("wr3_pend_e%0d", e), 32'(pend), 32'(expP));
    end

    // Write ch2 div=0, stored as 1: tick every cycle, toggle every cycle.
    doReset();
    for (int e = 1; e <= 10; e++) begin
      applyStimulus(e == 1, 2'd2, 8'd0, 1'b0);
      expT = (e % 5 == 0) ? 4'hF : 4'h0;
      expT[2] = (e >= 5);
      checkOutput($sformatf("d1_tick_e%0d", e), 32'(tick), 32'(expT));
      checkOutput($sformatf("d1_clk2_e%0d", e), 32'(clk_out[2]),
                  32'((e >= 5) && (e % 2 == 1)));
    end

    // Channel 0 disabled for edges 3..9 with cnt=2; ticks on the 3rd enabled edge.
    doReset();
    for (int e = 1; e <= 14; e++) begin
      enable = (e >= 3 && e <= 9) ? 4'b1110 : 4'hF;
      applyStimulus(1'b0, 2'd0, 8'd0, 1'b0);
      expT = (e % 5 == 0) ? 4'b1110 : 4'b0000;
      expT[0] = (e == 12);
      expC = (e >= 5 && e <= 9) ? 4'b1110 : 4'b0000;
      expC[0] = (e >= 12);
      checkOutput($sformatf("dis_tick_e%0d", e), 32'(tick), 32'(expT));
      checkOutput($sformatf("dis_clk_e%0d", e), 32'(clk_out), 32'(expC));
    end
    enable = 4'hF;

    // Divisors 4/6/5/5 drift apart; sync on edge 20 realigns and applies pending.
    doReset();
    for (int e = 1; e <= 30; e++) begin
      if (e == 1)       applyStimulus(1'b1, 2'd0, 8'd4, 1'b0);
      else if (e == 2)  applyStimulus(1'b1, 2'd1, 8'd6, 1'b0);
      else if (e == 17) applyStimulus(1'b1, 2'd2, 8'd3, 1'b0);
      else if (e == 20) applyStimulus(1'b1, 2'd3, 8'd2, 1'b1);
      else              applyStimulus(1'b0, 2'd0, 8'd0, 1'b0);
      expT[0] = (e == 5) || (e == 9) || (e == 13) || (e == 17) || (e == 24) || (e == 28);
      expT[1] = (e == 5) || (e == 11) || (e == 17) || (e == 26);
      expT[2] = (e == 5) || (e == 10) || (e == 15) || (e == 23) || (e == 26) || (e == 29);
      expT[3] = (e == 5) || (e == 10) || (e == 15) || (e == 25) || (e == 27) || (e == 29);
      checkOutput($sformatf("sync_tick_e%0d", e), 32'(tick), 32'(expT));
      if (e == 19) begin
        checkOutput("sync_pre_clk", 32'(clk_out), 32'hE);
        checkOutput("sync_pre_pend", 32'(pend), 32'h4);
      end
      if (e == 20) begin
        checkOutput("sync_clk", 32'(clk_out), 32'h0);
        checkOutput("sync_pend", 32'(pend), 32'h8);
      end
      if (e == 24) checkOutput("sync_pend_e24", 32'(pend), 32'h8);
      if (e == 25) checkOutput("sync_pend_e25", 32'(pend), 32'h0);
    end

    // Write on a terminal-count edge, then reset mid-count with a write present.
    doReset();
    for (int e = 1; e <= 16; e++) begin
      if (e == 16) reset = 1'b1;
      if (e == 1)       applyStimulus(1'b1, 2'd0, 8'd3, 1'b0);
      else if (e == 5)  applyStimulus(1'b1, 2'd0, 8'd2, 1'b0);
      else if (e == 13) applyStimulus(1'b1, 2'd1, 8'd7, 1'b0);
      else if (e == 16) applyStimulus(1'b1, 2'd0, 8'd9, 1'b0);
      else              applyStimulus(1'b0, 2'd0, 8'd0, 1'b0);
      if (e < 16) begin
        expT = (e % 5 == 0) ? 4'b1110 : 4'b0000;
        expT[0] = (e == 5) || (e == 8) || (e == 10) || (e == 12) || (e == 14);
        expP = 4'b0000;
        expP[0] = (e <= 7);
        expP[1] = (e == 13) || (e == 14);
        checkOutput($sformatf("tcw_tick_e%0d", e), 32'(tick), 32'(expT));
        checkOutput($sformatf("tcw_pend_e%0d", e), 32'(pend), 32'(expP));
      end
    end
    reset = 1'b0;
    checkOutput("midrst_tick", 32'(tick), 32'h0);
    checkOutput("midrst_clk_out", 32'(clk_out), 32'h0);
    checkOutput("midrst_pend", 32'(pend), 32'h0);

    // After release every channel is back on divisor 5; the 5-channel bank
    // ignores a write to channel 7.
    for (int e = 1; e <= 9; e++) begin
      wr_en5  = (e == 1);
      wr_ch5  = 3'd7;
      wr_div5 = 8'd1;
      applyStimulus(1'b0, 2'd0, 8'd0, 1'b0);
      wr_en5 = 1'b0;
      checkOutput($sformatf("post_tick_e%0d", e), 32'(tick),
                  (e == 5) ? 32'hF : 32'h0);
      checkOutput($sformatf("oor_tick_e%0d", e), 32'(tick5),
                  (e % 3 == 0) ? 32'h1F : 32'h0);
      checkOutput($sformatf("oor_pend_e%0d", e), 32'(pend5), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
